mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the load/store requester, so both streams can use a unified memory instance.
- Sits between fetch/LSU and the memory module.
- Grants one transaction at a time using fixed data-over-fetch priority, with a starvation override for fetch.
- Tracks the outstanding access and returns read data to its owner after a fixed memory latency.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- MEM_LATENCY, 1, cycles from issue to valid mem_data_i; legal range 1..4.
- STARVE_LIMIT, 4, consecutive cycles fetch may be denied before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req_i  in  1  fetch request; held with address until granted.
- if_addr_i  in  AWIDTH  fetch address.
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse.
- if_rdata_o  out  DWIDTH  fetch instruction word.
- d_req_i  in  1  data request; held with its fields until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  AWIDTH  data address.
- d_wdata_i  in  DWIDTH  store data.
- d_size_i  in  3  size encoding; passed unchanged to memory.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  load data valid or store ack, one-cycle pulse.
- d_rdata_o  out  DWIDTH  load data; 0 on store ack.
- mem_addr_o  out  AWIDTH  memory address.
- mem_data_o  out  DWIDTH  memory write data.
- mem_size_o  out  3  memory size encoding.
- mem_read_en_o  out  1  memory read enable.
- mem_write_en_o  out  1  memory write enable.
- mem_data_i  in  DWIDTH  memory read data.
- busy_o  out  1  a transaction is outstanding.

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: a transaction is outstanding. Registers: owner (IF/D), is_write, cnt[2:0].
- can_issue = (state==IDLE) || (state==BUSY && cnt==1).
- Grant selection, evaluated only when can_issue:
  - Only one requester active: that requester is granted.
  - Both active: D is granted unless starve==STARVE_LIMIT, in which case IF is granted.
  - Grants are combinational and one-hot; never both.
- Issue cycle (grant high):
  - mem_* outputs are driven combinationally from the granted requester.
  - Fetch issue: mem_size_o = 3'b010 (word), read_en=1, write_en=0, mem_data_o=0.
  - Data issue: read_en = ~d_we_i, write_en = d_we_i.
  - Next cycle: state=BUSY, cnt=MEM_LATENCY, owner and is_write are latched.
- No grant: all mem_* outputs are 0.
- BUSY countdown:
  - cnt decrements each cycle while cnt>1.
  - When cnt==1: the owner's rvalid pulses and rdata = mem_data_i (0 for a store).
  - If no new grant is made in that cycle, state goes to IDLE.
- Throughput: back-to-back issue is allowed in the response cycle, giving one transaction per MEM_LATENCY cycles.
- Latency: a request issued at cycle T gets rvalid at T+MEM_LATENCY.
- Starvation counter starve[3:0]:
  - Increments, saturating at STARVE_LIMIT, each cycle if_req_i=1 and if_gnt_o=0.
  - Clears on if_gnt_o or when if_req_i=0.
- Non-owner outputs: rvalid=0 and rdata=0.
- busy_o = (state==BUSY).
- Reset (applies mid-transaction too):
  - state=IDLE, cnt=0, starve=0, owner=IF.
  - All outputs are 0; any pending response is dropped with no rvalid.
  - Requests are not granted in the cycle rst is high.
- A request that drops before being granted is ignored; this is a protocol violation and must not corrupt the FSM.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds ports if_stall_cnt_o (32), d_stall_cnt_o (32) and xact_cnt_o (32), all outputs.
  - Stall counters count cycles a request is high but not granted.
  - xact_cnt_o counts grants.
  - All three are cleared by rst and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Fetch only, MEM_LATENCY=1, if_addr=0x01000000, mem_data_i=0x00000013 → if_gnt at T, if_rvalid at T+1 with 0x00000013, read_en=1, size=3'b010.
- Both requesting at T, D is a load of 0x01000100 → d_gnt at T, if_gnt at T+1 (back-to-back), d_rvalid at T+1, if_rvalid at T+2.
- d_req held high continuously, if_req high, STARVE_LIMIT=4 → IF is denied 4 consecutive issue slots, then if_gnt=1 on the 5th slot.
- Store: d_we=1, addr 0x01000200, wdata 0xDEADBEEF, size 3'b000 → write_en=1 for exactly one cycle with those values; d_rvalid at T+MEM_LATENCY with d_rdata=0.
- MEM_LATENCY=3, load issued at T, rst asserted at T+1 → no d_rvalid ever; busy_o=0 at T+2; a new if_req at T+2 is granted.
- With ARB_PERF_CNT_EN, 3 cycles of IF stall followed by a grant → if_stall_cnt_o=3, xact_cnt_o increments by 1 per grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the instruction-fetch
//               requester (IF) and the load/store requester (D). One
//               transaction is granted at a time: D wins over IF, except
//               when IF has been denied STARVE_LIMIT consecutive cycles.
//               Read data (or a store ack) is returned to the owner of the
//               outstanding access exactly MEM_LATENCY cycles after issue.
//               A new access may issue in the response cycle, so the port
//               sustains one transaction every MEM_LATENCY cycles.
//
// Parameters  : AWIDTH       address width
//               DWIDTH       data width
//               MEM_LATENCY  issue-to-data cycles (1..4)
//               STARVE_LIMIT denied cycles before IF is forced (1..15)
//
// Ports       : clk, rst                  clock, synchronous active-high reset
//               if_req_i/if_addr_i        fetch request and address
//               if_gnt_o                  fetch accepted this cycle
//               if_rvalid_o/if_rdata_o    fetch response (one-cycle pulse)
//               d_req_i/d_we_i/d_addr_i   data request, store flag, address
//               d_wdata_i/d_size_i        store data, size encoding
//               d_gnt_o                   data request accepted this cycle
//               d_rvalid_o/d_rdata_o      load data / store ack (rdata 0)
//               mem_*_o                   memory command (0 when no grant)
//               mem_data_i                memory read data
//               busy_o                    a transaction is outstanding
//
// Option      : `define ARB_PERF_CNT_EN adds if_stall_cnt_o, d_stall_cnt_o
//               and xact_cnt_o (32-bit, wrapping, cleared by rst).
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_size_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic [2:0]        mem_size_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt_o,
  output logic [31:0]       d_stall_cnt_o,
  output logic [31:0]       xact_cnt_o
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] LATENCY_C   = 3'(MEM_LATENCY);
  localparam logic [3:0] STARVE_C    = 4'(STARVE_LIMIT);
  localparam logic       OWNER_IF    = 1'b0;
  localparam logic       OWNER_D     = 1'b1;
  localparam logic [2:0] SIZE_WORD_C = 3'b010;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        owner, owner_nx;
  logic        is_write, is_write_nx;
  logic [3:0]  starve, starve_nx;

  logic        can_issue;
  logic        gnt_if;
  logic        gnt_d;
  logic        resp;

  // --------------------------------------------------------------------------
  // Grant selection and response detection
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_if    = 1'b0;
    gnt_d     = 1'b0;
    // The response cycle of the outstanding access is also an issue slot.
    can_issue = (state == IDLE) || (cnt == 3'd1);
    if (!rst && can_issue) begin
      if (if_req_i && (!d_req_i || (starve == STARVE_C))) begin
        gnt_if = 1'b1;
      end else if (d_req_i) begin
        gnt_d = 1'b1;
      end
    end
    resp = !rst && (state == BUSY) && (cnt == 3'd1);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    if_gnt_o       = gnt_if;
    d_gnt_o        = gnt_d;
    if_rvalid_o    = 1'b0;
    if_rdata_o     = '0;
    d_rvalid_o     = 1'b0;
    d_rdata_o      = '0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_size_o     = 3'b000;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    // Forced low while rst is high so a pending state never leaks out.
    busy_o         = !rst && (state == BUSY);

    if (resp) begin
      if (owner == OWNER_IF) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_data_i;
      end else begin
        d_rvalid_o  = 1'b1;
        // A store is acknowledged with zero data.
        d_rdata_o   = is_write ? '0 : mem_data_i;
      end
    end

    if (gnt_if) begin
      mem_addr_o    = if_addr_i;
      mem_size_o    = SIZE_WORD_C;
      mem_read_en_o = 1'b1;
    end else if (gnt_d) begin
      mem_addr_o     = d_addr_i;
      mem_data_o     = d_wdata_i;
      mem_size_o     = d_size_i;
      mem_read_en_o  = !d_we_i;
      mem_write_en_o = d_we_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    owner_nx    = owner;
    is_write_nx = is_write;
    starve_nx   = 4'd0;

    if (rst) begin
      state_nx    = IDLE;
      cnt_nx      = 3'd0;
      owner_nx    = OWNER_IF;
      is_write_nx = 1'b0;
    end else begin
      if (gnt_if || gnt_d) begin
        state_nx    = BUSY;
        cnt_nx      = LATENCY_C;
        owner_nx    = gnt_d ? OWNER_D : OWNER_IF;
        is_write_nx = gnt_d && d_we_i;
      end else if (state == BUSY) begin
        if (cnt > 3'd1) begin
          cnt_nx = cnt - 3'd1;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
        end
      end

      // Counts denied cycles of a live fetch request; any gap or grant clears.
      if (if_req_i && !gnt_if) begin
        starve_nx = (starve >= STARVE_C) ? STARVE_C : starve + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state    <= state_nx;
    cnt      <= cnt_nx;
    owner    <= owner_nx;
    is_write <= is_write_nx;
    starve   <= starve_nx;
  end

`ifdef ARB_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if_stall_cnt_o <= 32'd0;
      d_stall_cnt_o  <= 32'd0;
      xact_cnt_o     <= 32'd0;
    end else begin
      if (if_req_i && !gnt_if) begin
        if_stall_cnt_o <= if_stall_cnt_o + 32'd1;
      end
      if (d_req_i && !gnt_d) begin
        d_stall_cnt_o <= d_stall_cnt_o + 32'd1;
      end
      if (gnt_if || gnt_d) begin
        xact_cnt_o <= xact_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench. Two arbiters (MEM_LATENCY 1 and 3) are
//               driven independently; a transaction-level model tracks the
//               outstanding access as an issue timestamp and due cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [2:0]  d_size    [2];
  logic [31:0] mem_rdata [2];

  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [2:0]  mem_size  [2];
  logic        mem_re    [2];
  logic        mem_we    [2];
  logic        busy      [2];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] ifs_cnt   [2];
  logic [31:0] ds_cnt    [2];
  logic [31:0] xc_cnt    [2];
`endif

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIM)) dut0 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_gnt_o(if_gnt[0]),
    .if_rvalid_o(if_rvalid[0]), .if_rdata_o(if_rdata[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]),
    .d_wdata_i(d_wdata[0]), .d_size_i(d_size[0]), .d_gnt_o(d_gnt[0]),
    .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]),
    .mem_addr_o(mem_addr[0]), .mem_data_o(mem_wdata[0]), .mem_size_o(mem_size[0]),
    .mem_read_en_o(mem_re[0]), .mem_write_en_o(mem_we[0]),
    .mem_data_i(mem_rdata[0]), .busy_o(busy[0])
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt_o(ifs_cnt[0]), .d_stall_cnt_o(ds_cnt[0]), .xact_cnt_o(xc_cnt[0])
`endif
  );

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(LIM)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_gnt_o(if_gnt[1]),
    .if_rvalid_o(if_rvalid[1]), .if_rdata_o(if_rdata[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]),
    .d_wdata_i(d_wdata[1]), .d_size_i(d_size[1]), .d_gnt_o(d_gnt[1]),
    .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]),
    .mem_addr_o(mem_addr[1]), .mem_data_o(mem_wdata[1]), .mem_size_o(mem_size[1]),
    .mem_read_en_o(mem_re[1]), .mem_write_en_o(mem_we[1]),
    .mem_data_i(mem_rdata[1]), .busy_o(busy[1])
`ifdef ARB_PERF_CNT_EN
    , .if_stall_cnt_o(ifs_cnt[1]), .d_stall_cnt_o(ds_cnt[1]), .xact_cnt_o(xc_cnt[1])
`endif
  );

  // ---------------- reference model (timestamp based) ----------------
  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          next_free [2];   // first cycle a new issue is allowed
  int          due       [2];   // cycle the pending response appears
  bit          pend      [2];
  bit          pend_d    [2];   // pending access belongs to D
  bit          pend_wr   [2];
  int          stv       [2];
  bit          e_ifg     [2];
  bit          e_dg      [2];
  logic [31:0] m_ifs     [2];
  logic [31:0] m_ds      [2];
  logic [31:0] m_xc      [2];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Evaluate and compare all outputs away from the clock edge.
  task automatic half();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit          can;
      bit          resp;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic [2:0]  e_size;
      can      = (cyc >= next_free[k]);
      e_ifg[k] = !rst && can && if_req[k] && (!d_req[k] || stv[k] == LIM);
      e_dg[k]  = !rst && can && d_req[k] && !e_ifg[k];
      resp     = !rst && pend[k] && (due[k] == cyc);
      e_addr   = e_ifg[k] ? if_addr[k] : (e_dg[k] ? d_addr[k] : 32'd0);
      e_wd     = e_dg[k] ? d_wdata[k] : 32'd0;
      e_size   = e_ifg[k] ? 3'b010 : (e_dg[k] ? d_size[k] : 3'b000);
      chk($sformatf("if_gnt%0d", k), 32'(if_gnt[k]), 32'(e_ifg[k]));
      chk($sformatf("d_gnt%0d", k), 32'(d_gnt[k]), 32'(e_dg[k]));
      chk($sformatf("if_rvalid%0d", k), 32'(if_rvalid[k]), 32'(resp && !pend_d[k]));
      chk($sformatf("if_rdata%0d", k), if_rdata[k], (resp && !pend_d[k]) ? mem_rdata[k] : 32'd0);
      chk($sformatf("d_rvalid%0d", k), 32'(d_rvalid[k]), 32'(resp && pend_d[k]));
      chk($sformatf("d_rdata%0d", k), d_rdata[k],
          (resp && pend_d[k] && !pend_wr[k]) ? mem_rdata[k] : 32'd0);
      chk($sformatf("mem_addr%0d", k), mem_addr[k], e_addr);
      chk($sformatf("mem_wdata%0d", k), mem_wdata[k], e_wd);
      chk($sformatf("mem_size%0d", k), 32'(mem_size[k]), 32'(e_size));
      chk($sformatf("mem_re%0d", k), 32'(mem_re[k]), 32'(e_ifg[k] || (e_dg[k] && !d_we[k])));
      chk($sformatf("mem_we%0d", k), 32'(mem_we[k]), 32'(e_dg[k] && d_we[k]));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(!rst && pend[k]));
`ifdef ARB_PERF_CNT_EN
      chk($sformatf("if_stall_cnt%0d", k), ifs_cnt[k], m_ifs[k]);
      chk($sformatf("d_stall_cnt%0d", k), ds_cnt[k], m_ds[k]);
      chk($sformatf("xact_cnt%0d", k), xc_cnt[k], m_xc[k]);
`endif
    end
  endtask

  // Advance the model across the clock edge, then let inputs change.
  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 0; next_free[k] = cyc + 1; stv[k] = 0;
        m_ifs[k] = 0; m_ds[k] = 0; m_xc[k] = 0;
      end else begin
        if (pend[k] && due[k] == cyc) pend[k] = 0;
        if (e_ifg[k] || e_dg[k]) begin
          pend[k] = 1; due[k] = cyc + lat(k); next_free[k] = cyc + lat(k);
          pend_d[k] = e_dg[k]; pend_wr[k] = e_dg[k] && d_we[k];
          m_xc[k] = m_xc[k] + 1;
        end
        if (if_req[k] && !e_ifg[k]) begin
          stv[k] = (stv[k] + 1 > LIM) ? LIM : stv[k] + 1;
          m_ifs[k] = m_ifs[k] + 1;
        end else begin
          stv[k] = 0;
        end
        if (d_req[k] && !e_dg[k]) m_ds[k] = m_ds[k] + 1;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
      d_addr[k] = 0; d_wdata[k] = 0; d_size[k] = 0; mem_rdata[k] = 0;
      pend[k] = 0; pend_d[k] = 0; pend_wr[k] = 0; stv[k] = 0; next_free[k] = 0; due[k] = 0;
      e_ifg[k] = 0; e_dg[k] = 0; m_ifs[k] = 0; m_ds[k] = 0; m_xc[k] = 0;
    end
    @(posedge clk); @(posedge clk); #1;
    half(); adv();                      // reset state: everything zero
    rst = 1'b0;

    // 1) fetch only, latency 1
    if_req[0] = 1; if_addr[0] = 32'h0100_0000; mem_rdata[0] = 32'h0000_0013;
    half();
    chk("s1_if_gnt", 32'(if_gnt[0]), 32'd1);
    chk("s1_size", 32'(mem_size[0]), 32'd2);
    chk("s1_re", 32'(mem_re[0]), 32'd1);
    adv(); if_req[0] = 0;
    half();
    chk("s1_if_rvalid", 32'(if_rvalid[0]), 32'd1);
    chk("s1_if_rdata", if_rdata[0], 32'h0000_0013);
    adv();

    // 2) both request, D load wins, IF back-to-back
    if_req[0] = 1; if_addr[0] = 32'h0100_0004;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h0100_0100; d_size[0] = 3'b010;
    mem_rdata[0] = 32'h1234_5678;
    half();
    chk("s2_d_gnt", 32'(d_gnt[0]), 32'd1);
    chk("s2_if_gnt_lo", 32'(if_gnt[0]), 32'd0);
    adv(); d_req[0] = 0;
    half();
    chk("s2_if_gnt", 32'(if_gnt[0]), 32'd1);
    chk("s2_d_rvalid", 32'(d_rvalid[0]), 32'd1);
    chk("s2_d_rdata", d_rdata[0], 32'h1234_5678);
    adv(); if_req[0] = 0;
    half();
    chk("s2_if_rvalid", 32'(if_rvalid[0]), 32'd1);
    adv();

    // 3) starvation override
    d_req[0] = 1; if_req[0] = 1;
    for (int i = 0; i < LIM; i++) begin
      half();
      chk("s3_if_denied", 32'(if_gnt[0]), 32'd0);
      adv();
    end
    half();
    chk("s3_if_forced", 32'(if_gnt[0]), 32'd1);
    chk("s3_d_lost", 32'(d_gnt[0]), 32'd0);
    adv(); d_req[0] = 0; if_req[0] = 0;
    half(); adv();

    // 4) store, latency 3
    d_req[1] = 1; d_we[1] = 1; d_addr[1] = 32'h0100_0200; d_wdata[1] = 32'hDEAD_BEEF;
    d_size[1] = 3'b000; mem_rdata[1] = 32'hA5A5_A5A5;
    half();
    chk("s4_we", 32'(mem_we[1]), 32'd1);
    chk("s4_addr", mem_addr[1], 32'h0100_0200);
    chk("s4_wdata", mem_wdata[1], 32'hDEAD_BEEF);
    adv(); d_req[1] = 0; d_we[1] = 0;
    for (int i = 1; i < 3; i++) begin
      half();
      chk("s4_we_once", 32'(mem_we[1]), 32'd0);
      chk("s4_no_ack_yet", 32'(d_rvalid[1]), 32'd0);
      adv();
    end
    half();
    chk("s4_ack", 32'(d_rvalid[1]), 32'd1);
    chk("s4_ack_data", d_rdata[1], 32'd0);
    adv();

    // 5) reset mid-transaction, latency 3
    d_req[1] = 1; d_addr[1] = 32'h0100_0300;
    half();
    chk("s5_d_gnt", 32'(d_gnt[1]), 32'd1);
    adv(); d_req[1] = 0; rst = 1;
    half(); adv();
    rst = 0; if_req[1] = 1; if_addr[1] = 32'h0100_0400;
    half();
    chk("s5_busy", 32'(busy[1]), 32'd0);
    chk("s5_if_gnt", 32'(if_gnt[1]), 32'd1);
    adv(); if_req[1] = 0;
    for (int i = 0; i < 4; i++) begin
      half();
      chk("s5_no_d_rvalid", 32'(d_rvalid[1]), 32'd0);
      adv();
    end

`ifdef ARB_PERF_CNT_EN
    // 6) three IF stall cycles then a grant
    rst = 1; half(); adv(); rst = 0;
    d_req[0] = 1; if_req[0] = 1;
    for (int i = 0; i < 3; i++) begin half(); adv(); end
    d_req[0] = 0;
    half(); adv(); if_req[0] = 0;
    half();
    chk("s6_if_stall", ifs_cnt[0], 32'd3);
    chk("s6_xact", xc_cnt[0], 32'd4);
    adv();
`endif

    // 7) randomized traffic with holds, drops and occasional reset
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(if_req[k] && !e_ifg[k] && $urandom_range(0, 24) != 0)) begin
          if_req[k]  = ($urandom_range(0, 2) != 0);
          if_addr[k] = $urandom;
        end
        if (!(d_req[k] && !e_dg[k] && $urandom_range(0, 24) != 0)) begin
          d_req[k]   = ($urandom_range(0, 2) != 0);
          d_we[k]    = $urandom_range(0, 1) == 1;
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
          d_size[k]  = 3'($urandom_range(0, 7));
        end
        mem_rdata[k] = $urandom;
      end
      rst = ($urandom_range(0, 127) == 0);
      half(); adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
